// File: rtl/lut_layer_pipe_pkg.sv
// Shared types for the LUT layer pipeline: sequencer states and the
// channel-select width helper.
package lut_layer_pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } state_t;

   // A single-channel build still needs a 1-bit select port.
   function automatic int ch_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/lut_layer_pipe_if.sv
// Stream-in, stream-out and table-configuration signals of the LUT layer.
interface lut_layer_pipe_if
   import lut_layer_pipe_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1
) ();

   localparam int CH_W = ch_width(N_CH);

   logic                     s_valid;
   logic                     s_ready;
   logic [N_CH*IN_BITS-1:0]  s_data;
   logic                     m_valid;
   logic                     m_ready;
   logic [N_CH*OUT_BITS-1:0] m_data;
   logic                     cfg_req;
   logic                     cfg_ready;
   logic                     cfg_we;
   logic [CH_W-1:0]          cfg_ch;
   logic [IN_BITS-1:0]       cfg_addr;
   logic [OUT_BITS-1:0]      cfg_data;

   modport slave (
      input  s_valid, s_data, m_ready, cfg_req, cfg_we, cfg_ch, cfg_addr, cfg_data,
      output s_ready, m_valid, m_data, cfg_ready
   );

   modport master (
      output s_valid, s_data, m_ready, cfg_req, cfg_we, cfg_ch, cfg_addr, cfg_data,
      input  s_ready, m_valid, m_data, cfg_ready
   );

endinterface

// File: rtl/lut_table_ram.sv
// One channel's lookup table: single write port, registered read whose
// output register doubles as that channel's slice of the output stage.
module lut_table_ram #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IN_BITS-1:0]  waddr,
   input  logic [OUT_BITS-1:0] wdata,
   input  logic                re,
   input  logic [IN_BITS-1:0]  raddr,
   output logic [OUT_BITS-1:0] rdata
);

   logic [OUT_BITS-1:0] mem [2**IN_BITS];

   // Table storage is deliberately left out of reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/lut_layer_pipe.sv
// Two-stage LUT neuron layer with a RUN/DRAIN/LOAD sequencer that empties the
// pipeline before the tables may be rewritten.
module lut_layer_pipe
   import lut_layer_pipe_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1
) (
   input  logic             clk,
   input  logic             rst,
   lut_layer_pipe_if.slave  bus
);

   localparam int CH_W = ch_width(N_CH);

   state_t                   state, state_nxt;
   logic                     s1_valid;
   logic [N_CH*IN_BITS-1:0]  s1_addr;
   logic                     m_valid_r;
   logic [N_CH*OUT_BITS-1:0] rd_data;
   logic                     adv;
   logic                     cfg_wr;

   assign adv           = !m_valid_r || bus.m_ready;
   assign bus.s_ready   = adv && (state == RUN);
   assign bus.cfg_ready = (state == LOAD);
   assign bus.m_valid   = m_valid_r;
   assign bus.m_data    = rd_data;
   assign cfg_wr        = bus.cfg_we && (state == LOAD);

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // A dropped request wins over a finished drain: no load window opens.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (bus.cfg_req) state_nxt = DRAIN;
         DRAIN: begin
            if (!bus.cfg_req)                 state_nxt = RUN;
            else if (!s1_valid && !m_valid_r) state_nxt = LOAD;
         end
         LOAD:    if (!bus.cfg_req) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_addr   <= '0;
         m_valid_r <= 1'b0;
      end else if (adv) begin
         s1_valid  <= bus.s_valid && bus.s_ready;
         if (bus.s_valid && bus.s_ready) s1_addr <= bus.s_data;
         m_valid_r <= s1_valid;
      end
   end

   // Out-of-range channel selects match no table and are dropped.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(c);

      lut_table_ram #(
         .IN_BITS  (IN_BITS),
         .OUT_BITS (OUT_BITS)
      ) u_table (
         .clk   (clk),
         .rst   (rst),
         .we    (cfg_wr && (bus.cfg_ch == CH_IDX)),
         .waddr (bus.cfg_addr),
         .wdata (bus.cfg_data),
         .re    (adv && s1_valid),
         .raddr (s1_addr[c*IN_BITS +: IN_BITS]),
         .rdata (rd_data[c*OUT_BITS +: OUT_BITS])
      );
   end

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Self-checking bench for lut_layer_pipe: random streams against a table model.
module tb_lut_layer_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   bit         tbl [4][256];
   logic [3:0] exp_q[$];
   logic [3:0] got_q[$];

   always #5 clk = ~clk;

   lut_layer_pipe_if #(.N_CH(4), .IN_BITS(8), .OUT_BITS(1)) bus ();

   lut_layer_pipe #(.N_CH(4), .IN_BITS(8), .OUT_BITS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [3:0] model(input logic [31:0] d);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = tbl[c][d[c*8 +: 8]];
      return r;
   endfunction

   // Record every transfer as it will happen at the coming rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.s_valid && bus.s_ready) exp_q.push_back(model(bus.s_data));
         if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
   endtask

   // mode 0: parity tables, mode 1: random tables (ch2 entry 0x10 forced to 0)
   task automatic load_table(input int mode, output bit ok);
      logic [7:0] a8;
      bit v;
      ok = 1'b0;
      bus.cfg_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.cfg_ready) begin ok = 1'b1; break; end
         step();
      end
      if (ok) begin
         for (int ch = 0; ch < 4; ch++) begin
            for (int a = 0; a < 256; a++) begin
               a8 = a[7:0];
               if (mode == 0) v = (ch == 0) ? ^a8 : a8[0];
               else           v = 1'($urandom_range(0, 1));
               if (mode == 1 && ch == 2 && a == 16) v = 1'b0;
               bus.cfg_we   = 1'b1;
               bus.cfg_ch   = 2'(ch);
               bus.cfg_addr = a8;
               bus.cfg_data = v;
               step();
               tbl[ch][a] = v;
            end
         end
      end
      bus.cfg_we  = 1'b0;
      bus.cfg_req = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
      checks++; if (bus.m_data !== 4'b0)    begin errors++; $display("FAIL reset_m_data got=%b want=0000", bus.m_data); end
      checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready got=%b want=0", bus.cfg_ready); end
      checks++; if (bus.s_ready !== 1'b1)   begin errors++; $display("FAIL reset_s_ready got=%b want=1", bus.s_ready); end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_parity();
      bit ok;
      load_table(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL parity_enter_load got=timeout want=cfg_ready"); end
      clear_q();
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h0003_A5FF;
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL parity_accept got=%b want=1", bus.s_ready); end
      step();
      bus.s_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL parity_early_valid got=%b want=0", bus.m_valid); end
      step();
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL parity_latency got=%b want=1", bus.m_valid); end
      checks++; if (bus.m_data !== 4'b0110) begin errors++; $display("FAIL parity_data got=%b want=0110", bus.m_data); end
      step();
      step();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int first = -1, last = -1, cnt = 0;
      load_table(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_enter_load got=timeout want=cfg_ready"); end
      clear_q();
      bus.m_ready = 1'b1;
      for (int cyc = 0; cyc < 262; cyc++) begin
         bus.s_valid = (cyc < 256);
         bus.s_data  = $urandom;
         @(negedge clk);
         if (bus.m_valid) begin
            if (first < 0) first = cyc;
            last = cyc;
            cnt++;
         end
         step();
      end
      bus.s_valid = 1'b0;
      checks++; if (cnt != 256) begin errors++; $display("FAIL b2b_count got=%0d want=256", cnt); end
      checks++; if (last - first + 1 != 256) begin errors++; $display("FAIL b2b_consecutive got=%0d want=256", last - first + 1); end
      checks++; if (exp_q.size() != 256) begin errors++; $display("FAIL b2b_accepted got=%0d want=256", exp_q.size()); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_outputs got=%0d want=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%b want=%b", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] vec [40];
      logic [3:0]  held = '0;
      int idx = 0;
      for (int i = 0; i < 40; i++) vec[i] = $urandom;
      clear_q();
      for (int cyc = 0; cyc < 80; cyc++) begin
         bus.m_ready = !(cyc >= 12 && cyc < 17);
         bus.s_valid = (idx < 40);
         bus.s_data  = vec[(idx < 40) ? idx : 39];
         @(negedge clk);
         if (cyc == 12) begin
            held = bus.m_data;
            checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_full got=%b want=1", bus.m_valid); end
         end
         if (cyc >= 13 && cyc < 17) begin
            checks++; if (bus.m_data !== held) begin errors++; $display("FAIL bp_hold cyc=%0d got=%b want=%b", cyc, bus.m_data, held); end
         end
         if (cyc >= 12 && cyc < 17) begin
            checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready cyc=%0d got=%b want=0", cyc, bus.s_ready); end
         end
         if (bus.s_valid && bus.s_ready) idx++;
         step();
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      checks++; if (idx != 40) begin errors++; $display("FAIL bp_sent got=%0d want=40", idx); end
      checks++; if (got_q.size() != 40) begin errors++; $display("FAIL bp_outputs got=%0d want=40", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 40; i++) begin
         checks++;
         if (got_q[i] !== model(vec[i])) begin errors++; $display("FAIL bp_data[%0d] got=%b want=%b", i, got_q[i], model(vec[i])); end
      end
   endtask

   task automatic test_reload();
      logic [31:0] v0, v1, v2;
      bit ok = 1'b0;
      v0 = $urandom; v0[23:16] = 8'h10;
      v1 = $urandom; v1[23:16] = 8'h10;
      v2 = $urandom; v2[23:16] = 8'h10;
      clear_q();
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = v0;
      step();
      bus.s_data  = v1;
      step();
      bus.s_valid = 1'b0;
      bus.cfg_req = 1'b1;
      step();
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reload_s_ready got=%b want=0", bus.s_ready); end
      step();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.cfg_ready) begin ok = 1'b1; break; end
         step();
      end
      checks++; if (!ok) begin errors++; $display("FAIL reload_cfg_ready got=timeout want=1"); end
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL reload_inflight got=%0d want=2", got_q.size()); end
      if (got_q.size() == 2) begin
         checks++; if (got_q[0] !== model(v0)) begin errors++; $display("FAIL reload_old0 got=%b want=%b", got_q[0], model(v0)); end
         checks++; if (got_q[1] !== model(v1)) begin errors++; $display("FAIL reload_old1 got=%b want=%b", got_q[1], model(v1)); end
      end
      // write on the same edge that the request drops
      bus.cfg_req  = 1'b0;
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = 2'd2;
      bus.cfg_addr = 8'h10;
      bus.cfg_data = 1'b1;
      step();
      bus.cfg_we   = 1'b0;
      if (ok) tbl[2][16] = 1'b1;
      step();
      clear_q();
      bus.s_valid = 1'b1;
      bus.s_data  = v2;
      step();
      bus.s_valid = 1'b0;
      repeat (4) step();
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL reload_new_count got=%0d want=1", got_q.size()); end
      if (got_q.size() == 1) begin
         checks++; if (got_q[0][2] !== 1'b1) begin errors++; $display("FAIL reload_ch2 got=%b want=1", got_q[0][2]); end
         checks++; if (got_q[0] !== model(v2)) begin errors++; $display("FAIL reload_new got=%b want=%b", got_q[0], model(v2)); end
      end
   endtask

   task automatic test_illegal();
      logic [7:0]  a;
      logic [31:0] v;
      bit old;
      a = 8'($urandom);
      old = tbl[1][a];
      v = $urandom; v[15:8] = a;
      bus.m_ready  = 1'b1;
      bus.cfg_ch   = 2'd1;
      bus.cfg_addr = a;
      bus.cfg_data = ~old;
      bus.cfg_we   = 1'b1;
      step();
      bus.cfg_we  = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = v;
      step();
      bus.s_valid = 1'b0;
      bus.cfg_req = 1'b1;
      bus.cfg_we  = 1'b1;
      @(negedge clk);
      checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL illegal_ready_run got=%b want=0", bus.cfg_ready); end
      step();
      @(negedge clk);
      checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL illegal_ready_drain got=%b want=0", bus.cfg_ready); end
      step();
      bus.cfg_we  = 1'b0;
      bus.cfg_req = 1'b0;
      repeat (3) step();
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL illegal_back_to_run got=%b want=1", bus.s_ready); end
      step();
      clear_q();
      bus.s_valid = 1'b1;
      bus.s_data  = v;
      step();
      bus.s_valid = 1'b0;
      repeat (4) step();
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL illegal_count got=%0d want=1", got_q.size()); end
      if (got_q.size() == 1) begin
         checks++; if (got_q[0][1] !== old) begin errors++; $display("FAIL illegal_ch1 got=%b want=%b", got_q[0][1], old); end
         checks++; if (got_q[0] !== model(v)) begin errors++; $display("FAIL illegal_data got=%b want=%b", got_q[0], model(v)); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] vec [8];
      bus.m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = $urandom;
         step();
      end
      bus.s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full got=%b want=1", bus.m_valid); end
      step();
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got=%b want=0", bus.m_valid); end
      checks++; if (bus.m_data !== 4'b0)  begin errors++; $display("FAIL rstmid_m_data got=%b want=0000", bus.m_data); end
      step();
      rst = 1'b0;
      step();
      clear_q();
      for (int i = 0; i < 8; i++) begin
         vec[i] = $urandom;
         bus.s_valid = 1'b1;
         bus.s_data  = vec[i];
         step();
      end
      bus.s_valid = 1'b0;
      repeat (5) step();
      checks++; if (got_q.size() != 8) begin errors++; $display("FAIL rstmid_count got=%0d want=8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         checks++;
         if (got_q[i] !== model(vec[i])) begin errors++; $display("FAIL rstmid_data[%0d] got=%b want=%b", i, got_q[i], model(vec[i])); end
      end
   endtask

   initial begin
      bus.s_valid  = 1'b0;
      bus.s_data   = '0;
      bus.m_ready  = 1'b1;
      bus.cfg_req  = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      #1;
      test_reset();
      test_parity();
      test_back_to_back();
      test_backpressure();
      test_reload();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
